can_rx_destuff: RTL and testbench
=================================

# can_rx_destuff

Receive-side bit destuffer and frame tracker for the CAN 2.0 controller. Sits between the bit-timing/sampling stage and the CRC-15 LFSR. It consumes one sampled bus bit per `sample_en` strobe, detects SOF after bus idle, removes stuff bits, and flags stuff errors. It drives the destuffed bit plus a per-bit `crc_en` qualifier to the CRC block, and captures the received 15-bit CRC sequence for comparison downstream.

## Interface
- `IDLE_BITS`, default 11: consecutive recessive bits required before SOF is accepted.
- `clk`  input  1  system clock
- `rst`  input  1  synchronous, active-high reset
- `sample_en`  input  1  one-cycle strobe; `rx_bit` is valid this cycle
- `rx_bit`  input  1  sampled bus bit (1 = recessive)
- `dout`  output  1  destuffed bit
- `dout_valid`  output  1  one-cycle pulse per destuffed frame bit (SOF through last CRC bit)
- `crc_en`  output  1  one-cycle pulse, coincident with `dout_valid`, for bits covered by CRC (SOF through last data bit)
- `rx_crc`  output  15  received CRC sequence, MSB first
- `rx_crc_valid`  output  1  one-cycle pulse when `rx_crc` is complete
- `stuff_err`  output  1  one-cycle pulse on stuff-rule violation
- `busy`  output  1  high from SOF until frame end or error

## Operation
- States: SYNC, IDLE, HDR, DATA, CRC, TAIL.
- SYNC: count consecutive recessive samples; a dominant sample clears the count. At `IDLE_BITS`, go to IDLE.
- IDLE: a dominant sample is SOF. Emit it (`dout`=0, `dout_valid`, `crc_en`), then go to HDR. The stuff run starts at length 1, value 0.
- Stuff rule, applied from SOF through the last CRC bit:
  - Track run value and length over all received bits, stuff bits included.
  - After 5 equal bits, the next sample is a stuff bit. It is not emitted.
  - If the stuff bit differs from the run value: the run restarts at length 1 with the stuff bit's value.
  - If the stuff bit equals the run value: pulse `stuff_err`, drop `busy`, go to SYNC. No further `dout_valid` pulses until SYNC completes.
- HDR (standard frame): ID 11, RTR 1, IDE 1, r0 1, DLC 4 = 18 bits.
  - Latch RTR and DLC.
  - Data length = 0 if RTR=1; otherwise min(DLC,8)×8 bits.
  - Go to DATA, or directly to CRC if the length is 0.
- DATA: emit bits with `crc_en` until the length counter reaches 0.
- CRC: emit 15 bits with `dout_valid` only (no `crc_en`) and shift them MSB-first into `rx_crc`. Pulse `rx_crc_valid` with the 15th bit's `dout_valid`.
- TAIL: if the last CRC bit completed a run of 5, consume and check the following stuff bit (error rules as above), then go to SYNC. Otherwise go to SYNC immediately. SYNC then absorbs the CRC delimiter, ACK, EOF and intermission.
- `rx_crc` holds its value until the next `rx_crc_valid`.

## Timing
- All outputs registered. `dout`/`dout_valid`/`crc_en`/`stuff_err` appear the cycle after the `sample_en` that carried the bit.
- Back-to-back `sample_en` (every cycle) is supported at full rate. Gaps of any length between strobes are legal; state holds.
- Cycles without `sample_en` produce no pulses.
- Reset: state SYNC, counters 0, `dout`=0, `dout_valid`=0, `crc_en`=0, `rx_crc`=0, `rx_crc_valid`=0, `stuff_err`=0, `busy`=0.
- Reset asserted mid-frame aborts the frame the same cycle. No error pulse. SYNC must re-qualify idle.
- `rst` has priority over `sample_en` in the same cycle.
- `busy` rises with SOF's `dout_valid` and falls on the cycle leaving TAIL, or with `stuff_err`.

## Configuration
- `CAN_EXT_ID_EN` defined:
  - The IDE bit is honoured. IDE=1 extends HDR to ID 11, SRR 1, IDE 1, ID 18, RTR 1, r1 1, r0 1, DLC 4 = 38 bits.
  - RTR is taken from the bit after the 18-bit ID extension.
- Not defined:
  - HDR is always 18 bits; IDE is ignored.
  - A frame with IDE=1 is parsed as standard, and no extended-frame logic is synthesized.

## Test plan
- Reset, 11 recessive bits, standard frame ID=0x123, RTR=0, DLC=1, data 0xA5, valid CRC, continuous strobes -> 1+18+8=27 `crc_en` pulses, 42 `dout_valid` pulses, destuffed stream matches unstuffed reference, `rx_crc_valid` once with the transmitted CRC, `stuff_err` never.
- Frame with ID=0x000 (runs of 0s forcing stuff bits) -> every inserted 1 is removed. `dout` sequence equals the unstuffed frame; the bit count matches the unstuffed length exactly.
- Six consecutive dominant bits inside HDR -> `stuff_err` pulses once on the 6th bit's output cycle, `busy`=0. The next SOF is ignored until 11 recessive bits are seen.
- DLC=0xF, RTR=0 -> 64 data bits with `crc_en`. RTR=1, DLC=4 -> 0 data bits, CRC follows DLC directly.
- Same frame with `sample_en` asserted every 3rd cycle -> identical output bit sequence, and pulse count per strobe is unchanged.
- `rst` pulsed after the 10th data bit -> all outputs 0 next cycle. A following idle+frame decodes correctly.
- With `CAN_EXT_ID_EN`: IDE=1 frame, DLC=2 -> 1+38+16=55 `crc_en` pulses. Without the macro, the same stimulus yields 1+18+data pulses per the misparsed DLC.

Source files
------------

// File: rtl/can_rx_destuff_if.sv
// Bit-level bus between the sampling stage, the CAN receive destuffer and the CRC-15 block.
// The destuffer takes the slave modport; the bit source and sink take the master modport.
interface can_rx_destuff_if;
    logic        sample_en;
    logic        rx_bit;
    logic        dout;
    logic        dout_valid;
    logic        crc_en;
    logic [14:0] rx_crc;
    logic        rx_crc_valid;
    logic        stuff_err;
    logic        busy;

    modport master (
        output sample_en, rx_bit,
        input  dout, dout_valid, crc_en, rx_crc, rx_crc_valid, stuff_err, busy
    );

    modport slave (
        input  sample_en, rx_bit,
        output dout, dout_valid, crc_en, rx_crc, rx_crc_valid, stuff_err, busy
    );
endinterface

// File: rtl/can_rx_destuff.sv
// CAN receive bit destuffer and frame tracker: SOF detection, stuff removal, CRC capture.
// Define CAN_EXT_ID_EN to honour the IDE bit and parse 29-bit extended headers.
module can_rx_destuff #(
    parameter int unsigned IDLE_BITS = 11
) (
    input logic            clk,
    input logic            rst,
    can_rx_destuff_if.slave bus
);

    localparam int unsigned IDLE_W = (IDLE_BITS > 2) ? $clog2(IDLE_BITS) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BITS - 1);

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        HDR,
        DATA,
        CRC,
        TAIL
    } state_t;

    state_t            state;
    logic [IDLE_W-1:0] idle_cnt;
    logic              run_val;
    logic [2:0]        run_len;
    logic [5:0]        hdr_cnt;
    logic [6:0]        data_cnt;
    logic [3:0]        crc_cnt;
    logic              rtr;
    logic [3:0]        dlc;
    logic [13:0]       crc_shift;
`ifdef CAN_EXT_ID_EN
    logic              ide;
`endif

    logic       stuff_slot;
    logic       stuff_bad;
    logic [2:0] run_len_nxt;
    logic       hdr_last;
    logic       rtr_pos;
    logic [3:0] dlc_nxt;
    logic       rtr_nxt;
    logic [6:0] data_len;

    always_comb begin
        stuff_slot  = (run_len == 3'd5);
        stuff_bad   = stuff_slot && (bus.rx_bit == run_val);
        run_len_nxt = (bus.rx_bit == run_val) ? run_len + 3'd1 : 3'd1;
        hdr_last    = (hdr_cnt == 6'd17);
        rtr_pos     = (hdr_cnt == 6'd11);
`ifdef CAN_EXT_ID_EN
        // Extended header: bit 11 is SRR, real RTR sits after the 18-bit ID extension.
        if (ide) begin
            hdr_last = (hdr_cnt == 6'd37);
            rtr_pos  = (hdr_cnt == 6'd11) || (hdr_cnt == 6'd31);
        end
`endif
        // DLC is simply the last four header bits shifted in.
        dlc_nxt  = {dlc[2:0], bus.rx_bit};
        rtr_nxt  = rtr_pos ? bus.rx_bit : rtr;
        data_len = '0;
        if (!rtr_nxt) begin
            data_len = dlc_nxt[3] ? 7'd64 : {1'b0, dlc_nxt[2:0], 3'b000};
        end
    end

    always_ff @(posedge clk) begin
        bus.dout_valid   <= 1'b0;
        bus.crc_en       <= 1'b0;
        bus.rx_crc_valid <= 1'b0;
        bus.stuff_err    <= 1'b0;
        if (rst) begin
            state        <= SYNC;
            idle_cnt     <= '0;
            run_val      <= 1'b0;
            run_len      <= '0;
            hdr_cnt      <= '0;
            data_cnt     <= '0;
            crc_cnt      <= '0;
            rtr          <= 1'b0;
            dlc          <= '0;
            crc_shift    <= '0;
`ifdef CAN_EXT_ID_EN
            ide          <= 1'b0;
`endif
            bus.dout     <= 1'b0;
            bus.rx_crc   <= '0;
            bus.busy     <= 1'b0;
        end else begin
            case (state)
                SYNC: begin
                    if (bus.sample_en) begin
                        if (!bus.rx_bit) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_LAST) begin
                            idle_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end

                IDLE: begin
                    if (bus.sample_en && !bus.rx_bit) begin
                        bus.dout       <= 1'b0;
                        bus.dout_valid <= 1'b1;
                        bus.crc_en     <= 1'b1;
                        bus.busy       <= 1'b1;
                        run_val        <= 1'b0;
                        run_len        <= 3'd1;
                        hdr_cnt        <= '0;
                        rtr            <= 1'b0;
                        dlc            <= '0;
`ifdef CAN_EXT_ID_EN
                        ide            <= 1'b0;
`endif
                        state          <= HDR;
                    end
                end

                HDR, DATA, CRC: begin
                    if (bus.sample_en) begin
                        if (stuff_slot) begin
                            if (stuff_bad) begin
                                bus.stuff_err <= 1'b1;
                                bus.busy      <= 1'b0;
                                run_len       <= '0;
                                idle_cnt      <= '0;
                                state         <= SYNC;
                            end else begin
                                run_val <= bus.rx_bit;
                                run_len <= 3'd1;
                            end
                        end else begin
                            run_val        <= bus.rx_bit;
                            run_len        <= run_len_nxt;
                            bus.dout       <= bus.rx_bit;
                            bus.dout_valid <= 1'b1;
                            if (state == HDR) begin
                                bus.crc_en <= 1'b1;
                                hdr_cnt    <= hdr_cnt + 6'd1;
                                dlc        <= dlc_nxt;
                                rtr        <= rtr_nxt;
`ifdef CAN_EXT_ID_EN
                                if (hdr_cnt == 6'd12) ide <= bus.rx_bit;
`endif
                                if (hdr_last) begin
                                    data_cnt <= data_len;
                                    crc_cnt  <= '0;
                                    state    <= (data_len == '0) ? CRC : DATA;
                                end
                            end else if (state == DATA) begin
                                bus.crc_en <= 1'b1;
                                data_cnt   <= data_cnt - 7'd1;
                                if (data_cnt == 7'd1) begin
                                    crc_cnt <= '0;
                                    state   <= CRC;
                                end
                            end else begin
                                // Shadow register keeps rx_crc stable until the sequence completes.
                                crc_shift <= {crc_shift[12:0], bus.rx_bit};
                                crc_cnt   <= crc_cnt + 4'd1;
                                if (crc_cnt == 4'd14) begin
                                    bus.rx_crc       <= {crc_shift, bus.rx_bit};
                                    bus.rx_crc_valid <= 1'b1;
                                    state            <= TAIL;
                                end
                            end
                        end
                    end
                end

                TAIL: begin
                    if (!stuff_slot) begin
                        // No trailing stuff bit: a sample here already belongs to the delimiter.
                        bus.busy <= 1'b0;
                        run_len  <= '0;
                        state    <= SYNC;
                        idle_cnt <= '0;
                        if (bus.sample_en) idle_cnt <= IDLE_W'(bus.rx_bit);
                    end else if (bus.sample_en) begin
                        bus.stuff_err <= stuff_bad;
                        bus.busy      <= 1'b0;
                        run_len       <= '0;
                        idle_cnt      <= '0;
                        state         <= SYNC;
                    end
                end

                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_rx_destuff.sv
// Directed self-checking bench for can_rx_destuff; frames, CRC and stuffing built by the bench.
module tb_can_rx_destuff;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    can_rx_destuff_if bus();

    can_rx_destuff #(.IDLE_BITS(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int gap = 0;

    bit          frame_q[$];
    bit          stuffed_q[$];
    logic [14:0] exp_crc;

    int   n_valid = 0, n_crc_en = 0, n_crcv = 0, n_serr = 0, n_stray = 0, n_orphan = 0;
    bit   got_q[$];
    logic prev_se = 1'b0;

    int b_valid, b_crc_en, b_crcv, b_serr, b_stray, b_orphan, b_got;

    always @(posedge clk) prev_se <= bus.sample_en;

    always @(negedge clk) begin
        if (bus.dout_valid) begin
            n_valid++;
            got_q.push_back(bus.dout);
        end
        if (bus.crc_en) n_crc_en++;
        if (bus.crc_en && !bus.dout_valid) n_orphan++;
        if (bus.rx_crc_valid) n_crcv++;
        if (bus.stuff_err) n_serr++;
        if ((bus.dout_valid || bus.crc_en || bus.rx_crc_valid || bus.stuff_err) && !prev_se) n_stray++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic snap();
        b_valid  = n_valid;
        b_crc_en = n_crc_en;
        b_crcv   = n_crcv;
        b_serr   = n_serr;
        b_stray  = n_stray;
        b_orphan = n_orphan;
        b_got    = got_q.size();
    endtask

    task automatic drive_bit(input bit b);
        bus.sample_en = 1'b1;
        bus.rx_bit    = b;
        @(posedge clk); #1;
        bus.sample_en = 1'b0;
        bus.rx_bit    = 1'b1;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_idle(input int n);
        repeat (n) drive_bit(1'b1);
    endtask

    task automatic send_stuffed();
        foreach (stuffed_q[i]) drive_bit(stuffed_q[i]);
    endtask

    // CRC delimiter, dominant ACK slot, then a couple of recessive bits.
    task automatic send_trailer();
        drive_bit(1'b1);
        drive_bit(1'b0);
        send_idle(2);
    endtask

    task automatic finish_frame();
        logic [14:0] c;
        bit          nx;
        int          run;
        bit          last;
        c = '0;
        foreach (frame_q[i]) begin
            nx = frame_q[i] ^ c[14];
            c  = {c[13:0], 1'b0};
            if (nx) c = c ^ 15'h4599;
        end
        exp_crc = c;
        for (int i = 14; i >= 0; i--) frame_q.push_back(c[i]);
        stuffed_q.delete();
        run  = 0;
        last = 1'b1;
        foreach (frame_q[i]) begin
            stuffed_q.push_back(frame_q[i]);
            if (i == 0 || frame_q[i] != last) begin
                last = frame_q[i];
                run  = 1;
            end else begin
                run++;
            end
            if (run == 5) begin
                stuffed_q.push_back(!last);
                last = !last;
                run  = 1;
            end
        end
    endtask

    task automatic build_std(input logic [10:0] id, input bit rtr, input logic [3:0] dlc,
                             input logic [63:0] data);
        int nbytes;
        frame_q.delete();
        frame_q.push_back(1'b0);
        for (int i = 10; i >= 0; i--) frame_q.push_back(id[i]);
        frame_q.push_back(rtr);
        frame_q.push_back(1'b0);
        frame_q.push_back(1'b0);
        for (int i = 3; i >= 0; i--) frame_q.push_back(dlc[i]);
        nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 63; i >= 64 - nbytes * 8; i--) frame_q.push_back(data[i]);
        finish_frame();
    endtask

    task automatic build_ext(input logic [28:0] id, input bit rtr, input logic [3:0] dlc,
                             input logic [63:0] data);
        int nbytes;
        frame_q.delete();
        frame_q.push_back(1'b0);
        for (int i = 28; i >= 18; i--) frame_q.push_back(id[i]);
        frame_q.push_back(1'b1);
        frame_q.push_back(1'b1);
        for (int i = 17; i >= 0; i--) frame_q.push_back(id[i]);
        frame_q.push_back(rtr);
        frame_q.push_back(1'b0);
        frame_q.push_back(1'b0);
        for (int i = 3; i >= 0; i--) frame_q.push_back(dlc[i]);
        nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 63; i >= 64 - nbytes * 8; i--) frame_q.push_back(data[i]);
        finish_frame();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sample_en = 1'b1;
        bus.rx_bit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus.dout_valid !== 1'b0 || bus.crc_en !== 1'b0) begin
            $display("FAIL reset_pulses: dout_valid=%b crc_en=%b expected 0 0", bus.dout_valid, bus.crc_en); miscompares++; end
        vectors++; if (bus.dout !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL reset_levels: dout=%b busy=%b expected 0 0", bus.dout, bus.busy); miscompares++; end
        vectors++; if (bus.rx_crc !== 15'h0 || bus.rx_crc_valid !== 1'b0 || bus.stuff_err !== 1'b0) begin
            $display("FAIL reset_crc: rx_crc=%h rx_crc_valid=%b stuff_err=%b expected 0", bus.rx_crc, bus.rx_crc_valid, bus.stuff_err); miscompares++; end
        rst = 1'b0;
        bus.sample_en = 1'b0;
        bus.rx_bit = 1'b1;
        @(posedge clk); #1;
        // Ten recessive bits are not enough idle; the dominant bit must not be taken as SOF.
        snap();
        send_idle(10);
        drive_bit(1'b0);
        send_idle(3);
        vectors++; if (n_valid - b_valid !== 0) begin
            $display("FAIL short_idle: dout_valid pulses=%0d expected 0", n_valid - b_valid); miscompares++; end
    endtask

    task automatic test_basic();
        int errs;
        gap = 0;
        build_std(11'h123, 1'b0, 4'd1, {8'hA5, 56'h0});
        snap();
        send_idle(11);
        send_stuffed();
        send_trailer();
        errs = 0;
        for (int i = 0; i < frame_q.size(); i++) if (got_q[b_got + i] !== frame_q[i]) errs++;
        vectors++; if (n_crc_en - b_crc_en !== 27) begin
            $display("FAIL basic_crc_en: count=%0d expected 27", n_crc_en - b_crc_en); miscompares++; end
        vectors++; if (n_valid - b_valid !== 42) begin
            $display("FAIL basic_valid: count=%0d expected 42", n_valid - b_valid); miscompares++; end
        vectors++; if (errs !== 0) begin
            $display("FAIL basic_stream: bit errors=%0d expected 0", errs); miscompares++; end
        vectors++; if (n_crcv - b_crcv !== 1 || bus.rx_crc !== exp_crc) begin
            $display("FAIL basic_rx_crc: pulses=%0d rx_crc=%h expected 1 %h", n_crcv - b_crcv, bus.rx_crc, exp_crc); miscompares++; end
        vectors++; if (n_serr - b_serr !== 0 || n_orphan - b_orphan !== 0 || bus.busy !== 1'b0) begin
            $display("FAIL basic_misc: stuff_err=%0d orphan_crc_en=%0d busy=%b expected 0 0 0", n_serr - b_serr, n_orphan - b_orphan, bus.busy); miscompares++; end
    endtask

    task automatic test_zero_id();
        int errs;
        build_std(11'h000, 1'b0, 4'd0, 64'h0);
        snap();
        send_idle(11);
        send_stuffed();
        send_trailer();
        errs = 0;
        for (int i = 0; i < frame_q.size(); i++) if (got_q[b_got + i] !== frame_q[i]) errs++;
        vectors++; if (n_valid - b_valid !== 34) begin
            $display("FAIL zero_id_len: count=%0d expected 34", n_valid - b_valid); miscompares++; end
        vectors++; if (errs !== 0) begin
            $display("FAIL zero_id_stream: bit errors=%0d expected 0", errs); miscompares++; end
        vectors++; if (bus.rx_crc !== exp_crc || n_serr - b_serr !== 0) begin
            $display("FAIL zero_id_crc: rx_crc=%h stuff_err=%0d expected %h 0", bus.rx_crc, n_serr - b_serr, exp_crc); miscompares++; end
    endtask

    task automatic test_stuff_error();
        int errs;
        snap();
        send_idle(11);
        drive_bit(1'b0);
        vectors++; if (bus.busy !== 1'b1 || bus.dout_valid !== 1'b1) begin
            $display("FAIL sof_busy: busy=%b dout_valid=%b expected 1 1", bus.busy, bus.dout_valid); miscompares++; end
        repeat (4) drive_bit(1'b0);
        drive_bit(1'b0);
        vectors++; if (bus.stuff_err !== 1'b1 || bus.busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
            $display("FAIL stuff_err_pulse: stuff_err=%b busy=%b dout_valid=%b expected 1 0 0", bus.stuff_err, bus.busy, bus.dout_valid); miscompares++; end
        send_idle(5);
        drive_bit(1'b0);
        send_idle(3);
        drive_bit(1'b0);
        drive_bit(1'b1);
        vectors++; if (n_valid - b_valid !== 5 || n_serr - b_serr !== 1) begin
            $display("FAIL after_error: dout_valid=%0d stuff_err=%0d expected 5 1", n_valid - b_valid, n_serr - b_serr); miscompares++; end
        build_std(11'h123, 1'b0, 4'd1, {8'hA5, 56'h0});
        b_got = got_q.size();
        send_idle(11);
        send_stuffed();
        send_trailer();
        errs = 0;
        for (int i = 0; i < frame_q.size(); i++) if (got_q[b_got + i] !== frame_q[i]) errs++;
        vectors++; if (n_valid - b_valid !== 5 + 42 || errs !== 0) begin
            $display("FAIL error_recovery: dout_valid=%0d bit errors=%0d expected 47 0", n_valid - b_valid, errs); miscompares++; end
    endtask

    task automatic test_dlc();
        int errs;
        build_std(11'h7F0, 1'b0, 4'hF, 64'hDEADBEEF_01234567);
        snap();
        send_idle(11);
        send_stuffed();
        send_trailer();
        errs = 0;
        for (int i = 0; i < frame_q.size(); i++) if (got_q[b_got + i] !== frame_q[i]) errs++;
        vectors++; if (n_crc_en - b_crc_en !== 83 || n_valid - b_valid !== 98) begin
            $display("FAIL dlc15_counts: crc_en=%0d dout_valid=%0d expected 83 98", n_crc_en - b_crc_en, n_valid - b_valid); miscompares++; end
        vectors++; if (errs !== 0 || bus.rx_crc !== exp_crc) begin
            $display("FAIL dlc15_data: bit errors=%0d rx_crc=%h expected 0 %h", errs, bus.rx_crc, exp_crc); miscompares++; end
        build_std(11'h2AA, 1'b1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF);
        snap();
        send_idle(11);
        send_stuffed();
        send_trailer();
        errs = 0;
        for (int i = 0; i < frame_q.size(); i++) if (got_q[b_got + i] !== frame_q[i]) errs++;
        vectors++; if (n_crc_en - b_crc_en !== 19 || n_valid - b_valid !== 34) begin
            $display("FAIL rtr_counts: crc_en=%0d dout_valid=%0d expected 19 34", n_crc_en - b_crc_en, n_valid - b_valid); miscompares++; end
        vectors++; if (errs !== 0 || bus.rx_crc !== exp_crc) begin
            $display("FAIL rtr_data: bit errors=%0d rx_crc=%h expected 0 %h", errs, bus.rx_crc, exp_crc); miscompares++; end
    endtask

    task automatic test_gapped();
        int errs;
        gap = 2;
        build_std(11'h123, 1'b0, 4'd1, {8'hA5, 56'h0});
        snap();
        send_idle(11);
        send_stuffed();
        send_trailer();
        gap = 0;
        errs = 0;
        for (int i = 0; i < frame_q.size(); i++) if (got_q[b_got + i] !== frame_q[i]) errs++;
        vectors++; if (n_crc_en - b_crc_en !== 27 || n_valid - b_valid !== 42) begin
            $display("FAIL gapped_counts: crc_en=%0d dout_valid=%0d expected 27 42", n_crc_en - b_crc_en, n_valid - b_valid); miscompares++; end
        vectors++; if (errs !== 0 || n_crcv - b_crcv !== 1) begin
            $display("FAIL gapped_stream: bit errors=%0d rx_crc_valid=%0d expected 0 1", errs, n_crcv - b_crcv); miscompares++; end
        vectors++; if (n_stray - b_stray !== 0) begin
            $display("FAIL gapped_stray: pulses without strobe=%0d expected 0", n_stray - b_stray); miscompares++; end
    endtask

    task automatic test_reset_midframe();
        int seen;
        int idx;
        int errs;
        build_std(11'h155, 1'b0, 4'd2, {16'h3C3C, 48'h0});
        snap();
        send_idle(11);
        seen = 0;
        idx  = 0;
        while (seen < 29 && idx < stuffed_q.size()) begin
            drive_bit(stuffed_q[idx]);
            if (bus.dout_valid) seen++;
            idx++;
        end
        vectors++; if (seen !== 29) begin
            $display("FAIL midframe_reach: destuffed bits=%0d expected 29", seen); miscompares++; end
        rst = 1'b1;
        bus.sample_en = 1'b1;
        bus.rx_bit = 1'b0;
        @(posedge clk); #1;
        vectors++; if ({bus.dout, bus.dout_valid, bus.crc_en, bus.rx_crc_valid, bus.stuff_err, bus.busy} !== 6'b0 || bus.rx_crc !== 15'h0) begin
            $display("FAIL midframe_reset: outputs=%b rx_crc=%h expected 000000 0", {bus.dout, bus.dout_valid, bus.crc_en, bus.rx_crc_valid, bus.stuff_err, bus.busy}, bus.rx_crc); miscompares++; end
        rst = 1'b0;
        bus.sample_en = 1'b0;
        bus.rx_bit = 1'b1;
        @(posedge clk); #1;
        build_std(11'h123, 1'b0, 4'd1, {8'hA5, 56'h0});
        snap();
        send_stuffed();
        send_trailer();
        vectors++; if (n_valid - b_valid !== 0 || n_serr - b_serr !== 0) begin
            $display("FAIL requalify_idle: dout_valid=%0d stuff_err=%0d expected 0 0", n_valid - b_valid, n_serr - b_serr); miscompares++; end
        send_idle(11);
        send_stuffed();
        send_trailer();
        errs = 0;
        for (int i = 0; i < frame_q.size(); i++) if (got_q[b_got + i] !== frame_q[i]) errs++;
        vectors++; if (n_valid - b_valid !== 42 || errs !== 0 || bus.rx_crc !== exp_crc) begin
            $display("FAIL post_reset_frame: dout_valid=%0d bit errors=%0d rx_crc=%h expected 42 0 %h", n_valid - b_valid, errs, bus.rx_crc, exp_crc); miscompares++; end
    endtask

    task automatic test_ext();
        int errs;
        logic [14:0] mis_crc;
        build_ext(29'h12345678, 1'b0, 4'd2, {16'hBEEF, 48'h0});
        snap();
        send_idle(11);
        send_stuffed();
        send_trailer();
`ifdef CAN_EXT_ID_EN
        errs = 0;
        for (int i = 0; i < frame_q.size(); i++) if (got_q[b_got + i] !== frame_q[i]) errs++;
        vectors++; if (n_crc_en - b_crc_en !== 55 || n_valid - b_valid !== 70) begin
            $display("FAIL ext_counts: crc_en=%0d dout_valid=%0d expected 55 70", n_crc_en - b_crc_en, n_valid - b_valid); miscompares++; end
        vectors++; if (errs !== 0 || bus.rx_crc !== exp_crc) begin
            $display("FAIL ext_data: bit errors=%0d rx_crc=%h expected 0 %h", errs, bus.rx_crc, exp_crc); miscompares++; end
`else
        // Parsed as standard: SRR (recessive) lands in the RTR slot, so no data field.
        errs = 0;
        for (int i = 0; i < 34; i++) if (got_q[b_got + i] !== frame_q[i]) errs++;
        for (int i = 0; i < 15; i++) mis_crc[14 - i] = frame_q[19 + i];
        vectors++; if (n_crc_en - b_crc_en !== 19 || n_valid - b_valid !== 34) begin
            $display("FAIL ext_misparse_counts: crc_en=%0d dout_valid=%0d expected 19 34", n_crc_en - b_crc_en, n_valid - b_valid); miscompares++; end
        vectors++; if (errs !== 0 || bus.rx_crc !== mis_crc) begin
            $display("FAIL ext_misparse_data: bit errors=%0d rx_crc=%h expected 0 %h", errs, bus.rx_crc, mis_crc); miscompares++; end
`endif
        vectors++; if (n_serr - b_serr !== 0 || n_crcv - b_crcv !== 1) begin
            $display("FAIL ext_flags: stuff_err=%0d rx_crc_valid=%0d expected 0 1", n_serr - b_serr, n_crcv - b_crcv); miscompares++; end
    endtask

    initial begin
        bus.sample_en = 1'b0;
        bus.rx_bit    = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_zero_id();
        test_stuff_error();
        test_dlc();
        test_gapped();
        test_reset_midframe();
        test_ext();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
